// File: rtl/tag_mem_array.sv
// tag_mem_array: three-bank word array answering the PC_B/WE/SE strobe protocol,
// with 1-cycle read latency from precharge and single-cycle protocol-error pulses.
module tag_mem_array #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PC_B,
    input  logic             WE,
    input  logic             SE,
    input  logic [5:0]       mem_address,
    input  logic [2:0]       mem_sel,
    input  logic [1:0]       RorW,
    input  logic [WIDTH-1:0] mem_data_in,
    output logic [WIDTH-1:0] mem_read_out,
    output logic             access_done,
    output logic             proto_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, PRECH, ACCESS} state_t;
    state_t           state;
    logic [WIDTH-1:0] mem [3][DEPTH];
    logic [1:0]       bank;
    logic [5:0]       addr;
    logic             wr;
    logic             req_ok;
    logic [1:0]       sel_idx;
    assign req_ok  = (mem_sel == 3'b001 || mem_sel == 3'b010 || mem_sel == 3'b100) &&
                     (RorW == 2'b01 || RorW == 2'b10) && int'(mem_address) < DEPTH;
    assign sel_idx = mem_sel[2] ? 2'd2 : mem_sel[1] ? 2'd1 : 2'd0;
    assign busy    = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mem_read_out <= '0;
            access_done  <= 1'b0;
            proto_err    <= 1'b0;
            bank         <= '0;
            addr         <= '0;
            wr           <= 1'b0;
            for (int b = 0; b < 3; b++)
                for (int a = 0; a < DEPTH; a++)
                    mem[b][a] <= '0;
        end else begin
            access_done <= 1'b0;
            proto_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!PC_B) begin
                        if (req_ok) begin
                            state <= PRECH;
                            bank  <= sel_idx;
                            addr  <= mem_address;
                            wr    <= RorW[1];
                            if (!RorW[1])
                                mem_read_out <= mem[sel_idx][mem_address];
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end else if (SE || WE) begin
                        proto_err <= 1'b1;
                    end
                end
                PRECH: begin
                    // both strobes, SE on a write, or WE on a read are all violations
                    if (PC_B && (SE || WE)) begin
                        if (SE == WE || SE == wr) begin
                            proto_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            if (WE)
                                mem[bank][addr] <= mem_data_in;
                            access_done <= 1'b1;
                            state       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!PC_B) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else if (!SE && !WE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tag_mem_array.sv
// tb_tag_mem_array: directed test-plan sequences plus randomized traffic, checked every
// cycle against a transaction-level model of the array.
module tb_tag_mem_array;
    localparam int DEPTH = 64;
    localparam int WIDTH = 16;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             PC_B = 1'b1;
    logic             WE = 1'b0;
    logic             SE = 1'b0;
    logic [5:0]       mem_address = '0;
    logic [2:0]       mem_sel = 3'b001;
    logic [1:0]       RorW = 2'b01;
    logic [WIDTH-1:0] mem_data_in = '0;
    logic [WIDTH-1:0] mem_read_out;
    logic             access_done, proto_err, busy;
    int total = 0;
    int bad = 0;

    tag_mem_array #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .PC_B(PC_B), .WE(WE), .SE(SE),
        .mem_address(mem_address), .mem_sel(mem_sel), .RorW(RorW),
        .mem_data_in(mem_data_in), .mem_read_out(mem_read_out),
        .access_done(access_done), .proto_err(proto_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an access is "open" from a legal precharge until it closes; "strobed" once
    // its single sense/write has been accepted.
    logic [WIDTH-1:0] e_mem [3][DEPTH];
    logic [WIDTH-1:0] e_rd;
    bit e_done, e_err, m_open, m_strobed, m_wr;
    int m_bank, m_addr;

    task automatic model_clear();
        foreach (e_mem[b, a]) e_mem[b][a] = '0;
        e_rd = '0; e_done = 0; e_err = 0; m_open = 0; m_strobed = 0; m_wr = 0;
        m_bank = 0; m_addr = 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_clear();
            end else begin
                e_done = 0;
                e_err = 0;
                if (!m_open) begin
                    if (!PC_B) begin
                        if ($countones(mem_sel) == 1 && (RorW == 2'b01 || RorW == 2'b10) &&
                            int'(mem_address) < DEPTH) begin
                            m_open = 1; m_strobed = 0;
                            m_bank = mem_sel[0] ? 0 : mem_sel[1] ? 1 : 2;
                            m_addr = int'(mem_address);
                            m_wr = (RorW == 2'b10);
                            if (!m_wr) e_rd = e_mem[m_bank][m_addr];
                        end else e_err = 1;
                    end else if (SE || WE) e_err = 1;
                end else if (!m_strobed) begin
                    if (PC_B && (SE || WE)) begin
                        if ((SE && WE) || (SE && m_wr) || (WE && !m_wr)) begin
                            e_err = 1; m_open = 0;
                        end else begin
                            if (WE) e_mem[m_bank][m_addr] = mem_data_in;
                            e_done = 1; m_strobed = 1;
                        end
                    end
                end else begin
                    if (!PC_B) begin e_err = 1; m_open = 0; end
                    else if (!SE && !WE) m_open = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("read_out", mem_read_out, e_rd);
            chk("access_done", 16'(access_done), 16'(e_done));
            chk("proto_err", 16'(proto_err), 16'(e_err));
            chk("busy", 16'(busy), 16'(m_open));
        end
    end

    task automatic drive(input logic pcb, input logic we, input logic se);
        @(posedge clk);
        #1;
        PC_B = pcb; WE = we; SE = se;
    endtask

    task automatic setup(input logic [2:0] sel, input logic [5:0] a, input logic [1:0] rw);
        mem_sel = sel; mem_address = a; RorW = rw;
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [5:0] a, input logic [WIDTH-1:0] d);
        drive(1'b0, 1'b0, 1'b0);
        setup(sel, a, 2'b10);
        drive(1'b1, 1'b1, 1'b0);
        mem_data_in = d;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("wr_done_pulse", 16'(access_done), 16'd1);
    endtask

    task automatic do_read(input logic [2:0] sel, input logic [5:0] a, input logic [WIDTH-1:0] exp);
        drive(1'b0, 1'b0, 1'b0);
        setup(sel, a, 2'b01);
        drive(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("rd_latency1", mem_read_out, exp);
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rd_done_pulse", 16'(access_done), 16'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_read_out", mem_read_out, 16'h0000);
        chk("reset_busy", 16'(busy), 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        do_write(3'b001, 6'd5, 16'hA5C3);
        do_read(3'b001, 6'd5, 16'hA5C3);

        do_write(3'b010, 6'd0, 16'h1111);
        do_write(3'b100, 6'd0, 16'h2222);
        do_read(3'b010, 6'd0, 16'h1111);
        do_read(3'b100, 6'd0, 16'h2222);
        do_read(3'b001, 6'd0, 16'h0000);

        held = mem_read_out;
        drive(1'b0, 1'b0, 1'b0);
        setup(3'b011, 6'd1, 2'b01);
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bad_sel_err", 16'(proto_err), 16'd1);
        chk("bad_sel_busy", 16'(busy), 16'd0);
        drive(1'b0, 1'b0, 1'b0);
        setup(3'b001, 6'd5, 2'b11);
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bad_op_err", 16'(proto_err), 16'd1);
        chk("bad_op_busy", 16'(busy), 16'd0);
        chk("bad_op_hold", mem_read_out, held);

        drive(1'b0, 1'b0, 1'b0);
        setup(3'b001, 6'd5, 2'b01);
        mem_data_in = 16'hDEAD;
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("conflict_err", 16'(proto_err), 16'd1);
        chk("conflict_idle", 16'(busy), 16'd0);
        drive(1'b1, 1'b0, 1'b0);
        do_read(3'b001, 6'd5, 16'hA5C3);

        drive(1'b0, 1'b0, 1'b0);
        setup(3'b100, 6'd9, 2'b10);
        mem_data_in = 16'hFFFF;
        drive(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_read_out", mem_read_out, 16'h0000);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(access_done), 16'd0);
        chk("rst_err", 16'(proto_err), 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        do_read(3'b100, 6'd9, 16'h0000);
        do_read(3'b001, 6'd5, 16'h0000);

        do_write(3'b100, 6'd2, 16'h0C02);
        do_write(3'b100, 6'd1, 16'h0C01);
        do_write(3'b100, 6'd0, 16'h0C00);
        do_read(3'b100, 6'd2, 16'h0C02);
        do_read(3'b100, 6'd1, 16'h0C01);
        do_read(3'b100, 6'd0, 16'h0C00);

        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 9) < 8) begin
                logic rd;
                rd = 1'($urandom_range(0, 1));
                drive(1'b0, 1'b0, 1'b0);
                setup(3'b001 << $urandom_range(0, 2), 6'($urandom_range(0, 7)), rd ? 2'b01 : 2'b10);
                repeat ($urandom_range(0, 2)) drive(1'b1, 1'b0, 1'b0);
                mem_data_in = 16'($urandom);
                drive(1'b1, !rd, rd);
                repeat ($urandom_range(0, 2)) begin
                    drive(1'b1, !rd, rd);
                    mem_data_in = 16'($urandom);
                end
                drive(1'b1, 1'b0, 1'b0);
            end else begin
                repeat ($urandom_range(1, 3)) begin
                    drive(1'($urandom), 1'($urandom), 1'($urandom));
                    setup(3'($urandom), 6'($urandom_range(0, 7)), 2'($urandom));
                    mem_data_in = 16'($urandom);
                end
                drive(1'b1, 1'b0, 1'b1);
                drive(1'b1, 1'b0, 1'b0);
                drive(1'b1, 1'b0, 1'b0);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
